roi_color_classifier: RTL and testbench
=======================================

Name: roi_color_classifier

Overview:
- Parametrised successor to the fixed RGB ROI detector.
- Classifies each RGB888 pixel in a runtime-programmable ROI into one of NUM_COLORS programmable colour classes and accumulates per-class counts over a frame.
- Picks the frame winner with a sequential arg-max and debounces it across frames before handing a stable result to the game FSM.
- Sits between ImgMemReader_ColorDetect and the dice/game FSM.

Parameters:
- NUM_COLORS, 4, number of colour classes (1..8); winner code = class index+1, 0 = NONE.
- COORD_W, 10, width of x/y coordinates and ROI bounds.
- COUNT_W, 16, width of per-class pixel counters (saturating).
- STABLE_FRAMES, 3, consecutive identical winners required before stable_valid.
- MIN_PIXELS, 50, winner count must be strictly greater than this, else result is NONE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- pixel_valid  in  1  pixel qualifier
- frame_start  in  1  frame boundary; only its rising edge is used
- x_coord, y_coord  in  COORD_W each  pixel coordinates
- pixel_r, pixel_g, pixel_b  in  8 each  RGB888 pixel
- roi_x0, roi_x1, roi_y0, roi_y1  in  COORD_W each  ROI bounds; x0 <= x < x1, y0 <= y < y1; sampled per pixel
- cfg_we  in  1  threshold write strobe
- cfg_idx  in  3  class index to write
- cfg_data  in  48  {rmin,rmax,gmin,gmax,bmin,bmax}, 8 bits each
- pix_class  out  4  registered class code of the previous-cycle pixel (0 = none or outside ROI)
- in_roi  out  1  combinational ROI hit for the current pixel
- frame_color  out  4  winner of the last completed frame
- frame_count  out  COUNT_W  winner's pixel count (0 if NONE)
- color_valid  out  1  1-cycle pulse when frame_color updates
- stable_color  out  4  debounced winner
- stable_valid  out  1  1-cycle pulse when stable_color changes
- overrun  out  1  1-cycle pulse when a frame result is dropped
- busy  out  1  high while the arg-max is running

Behaviour:
- Reset: all outputs 0; all counters 0; FSM in ACCUM; stable run counter 0; threshold table cleared (min=255, max=0, so nothing matches).
- Threshold write: on cfg_we, table[cfg_idx] <= cfg_data. Takes effect on the next cycle's pixel. Writes with cfg_idx >= NUM_COLORS are ignored.
- Class match: class k matches when rmin_k <= R <= rmax_k, and the same for G and B. Bounds are inclusive.
- Class priority: the lowest matching index wins.
- Stage 1: registers the pixel's class code (0 if !pixel_valid or !in_roi) into pix_class.
- Stage 2: increments count[pix_class-1], saturating at 2^COUNT_W-1.
- Frame end: defined as a frame_start rising edge, detected with a registered delay.
- On frame end:
  - snapshot[k] <= count[k], including any stage-1 pixel landing that cycle;
  - count[k] <= 0;
  - FSM ACCUM -> SCAN.
- SCAN:
  - One class per cycle, idx 0..NUM_COLORS-1.
  - Replace best only when snapshot[idx] > best, so ties go to the lower index.
  - After the last class, go to DECIDE.
- DECIDE (1 cycle):
  - frame_color = best_idx+1 if best > MIN_PIXELS, else 0.
  - frame_count is set to match.
  - color_valid pulses.
  - FSM returns to ACCUM.
  - Latency from the frame_start edge to color_valid: NUM_COLORS+2 cycles.
- busy is high in SCAN and DECIDE.
- Accumulation of the new frame continues during SCAN/DECIDE.
- A frame end while busy: snapshot is not overwritten, counts still clear, overrun pulses, and that frame's result is lost.
- Debounce, evaluated in DECIDE:
  - If the new winner equals the previous frame_color, run = min(run+1, STABLE_FRAMES); otherwise run = 1.
  - When run reaches STABLE_FRAMES and the winner differs from stable_color, stable_color updates and stable_valid pulses in the same cycle as color_valid.
  - NONE is a legal stable value.
- frame_start held high for multiple cycles counts as one frame end.
- Reset mid-SCAN aborts with no color_valid.

Optional Feature:
- Macro: COLOR_HIST_READ_EN.
- When defined, adds ports hist_idx (in, 3) and hist_count (out, COUNT_W).
  - hist_count is registered: snapshot[hist_idx] one cycle later, 0 for out-of-range indices.
  - Used by the debug overlay.
- When undefined, these ports and the read mux are absent. Snapshots remain internal and all other behaviour is identical.

Test Plan:
- Program class0 = red {180,255,0,99,0,99}, ROI 100..220 x 60..180. Send 200 pixels (250,20,20) in ROI, then a frame_start edge -> color_valid at +6 cycles (NUM_COLORS=4), frame_color=1, frame_count=200.
- 40 matching pixels, then frame end -> frame_color=0, frame_count=0. 51 pixels -> frame_color=1.
- Class0 and class1 both get 100 pixels -> frame_color=1 (tie goes to the lower index). Overlapping thresholds: a pixel matching classes 1 and 2 -> pix_class=2 only.
- Frames with winners green, green, green, red -> stable_valid pulses on the third frame with stable_color=2. The fourth frame gives frame_color=1 with no stable_valid.
- A second frame_start edge 2 cycles after the first -> overrun pulse, one color_valid only. The next frame's counts start from 0.
- Pixels outside the ROI (x=99, x=220) and pixel_valid=0 are never counted. Assert reset during SCAN -> all outputs 0, no color_valid.

Source files
------------

// File: rtl/roi_color_classifier_if.sv
// Pixel, configuration and frame-result bundle for roi_color_classifier.
// hist_idx/hist_count are present only when COLOR_HIST_READ_EN is defined.
interface roi_color_classifier_if #(
  parameter int COORD_W = 10,
  parameter int COUNT_W = 16
);
  logic               pixel_valid;
  logic               frame_start;
  logic [COORD_W-1:0] x_coord;
  logic [COORD_W-1:0] y_coord;
  logic [7:0]         pixel_r;
  logic [7:0]         pixel_g;
  logic [7:0]         pixel_b;
  logic [COORD_W-1:0] roi_x0;
  logic [COORD_W-1:0] roi_x1;
  logic [COORD_W-1:0] roi_y0;
  logic [COORD_W-1:0] roi_y1;
  logic               cfg_we;
  logic [2:0]         cfg_idx;
  logic [47:0]        cfg_data;
  logic [3:0]         pix_class;
  logic               in_roi;
  logic [3:0]         frame_color;
  logic [COUNT_W-1:0] frame_count;
  logic               color_valid;
  logic [3:0]         stable_color;
  logic               stable_valid;
  logic               overrun;
  logic               busy;
`ifdef COLOR_HIST_READ_EN
  logic [2:0]         hist_idx;
  logic [COUNT_W-1:0] hist_count;
`endif

  modport master (
    output pixel_valid, frame_start, x_coord, y_coord, pixel_r, pixel_g, pixel_b,
    output roi_x0, roi_x1, roi_y0, roi_y1, cfg_we, cfg_idx, cfg_data,
`ifdef COLOR_HIST_READ_EN
    output hist_idx,
    input  hist_count,
`endif
    input  pix_class, in_roi, frame_color, frame_count, color_valid,
    input  stable_color, stable_valid, overrun, busy
  );

  modport slave (
    input  pixel_valid, frame_start, x_coord, y_coord, pixel_r, pixel_g, pixel_b,
    input  roi_x0, roi_x1, roi_y0, roi_y1, cfg_we, cfg_idx, cfg_data,
`ifdef COLOR_HIST_READ_EN
    input  hist_idx,
    output hist_count,
`endif
    output pix_class, in_roi, frame_color, frame_count, color_valid,
    output stable_color, stable_valid, overrun, busy
  );
endinterface

// File: rtl/roi_color_classifier.sv
// ROI colour classifier: per-pixel class match, per-frame class histogram, sequential arg-max
// and cross-frame debounce. Optional snapshot read port enabled by macro COLOR_HIST_READ_EN.
module roi_color_classifier #(
  parameter int NUM_COLORS    = 4,
  parameter int COORD_W       = 10,
  parameter int COUNT_W       = 16,
  parameter int STABLE_FRAMES = 3,
  parameter int MIN_PIXELS    = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  roi_color_classifier_if.slave pix_if
);

  typedef enum logic [1:0] {ACCUM = 2'd0, SCAN = 2'd1, DECIDE = 2'd2} state_e;

  localparam int                 RUN_W     = $clog2(STABLE_FRAMES + 1);
  localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(STABLE_FRAMES);
  localparam logic [RUN_W-1:0]   RUN_ONE   = RUN_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] MIN_CNT   = COUNT_W'(MIN_PIXELS);
  localparam logic [47:0]        THR_CLEAR = 48'hFF00_FF00_FF00;
  localparam logic [2:0]         LAST_IDX  = 3'(NUM_COLORS - 1);

  function automatic logic thr_match(input logic [47:0] thr, input logic [7:0] r,
                                     input logic [7:0] g, input logic [7:0] b);
    thr_match = (r >= thr[47:40]) && (r <= thr[39:32]) &&
                (g >= thr[31:24]) && (g <= thr[23:16]) &&
                (b >= thr[15:8])  && (b <= thr[7:0]);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt, input logic inc);
    sat_inc = (inc && (cnt != CNT_MAX)) ? (cnt + CNT_ONE) : cnt;
  endfunction

  state_e             state_q, state_d;
  logic [47:0]        thr_q   [NUM_COLORS];
  logic [COUNT_W-1:0] count_q [NUM_COLORS];
  logic [COUNT_W-1:0] snap_q  [NUM_COLORS];
  logic               fs_q, fend_q;
  logic               in_roi_s;
  logic [3:0]         class_s, pix_class_q;
  logic [2:0]         idx_q, idx_d, best_idx_q, best_idx_d;
  logic [COUNT_W-1:0] best_q, best_d, snap_sel_s;
  logic [3:0]         win_s;
  logic [3:0]         frame_color_q, frame_color_d, stable_color_q, stable_color_d;
  logic [COUNT_W-1:0] frame_count_q, frame_count_d;
  logic               color_valid_q, color_valid_d, stable_valid_q, stable_valid_d;
  logic               overrun_q, busy_q;
  logic [RUN_W-1:0]   run_q, run_d;

  assign in_roi_s = (pix_if.x_coord >= pix_if.roi_x0) && (pix_if.x_coord < pix_if.roi_x1) &&
                    (pix_if.y_coord >= pix_if.roi_y0) && (pix_if.y_coord < pix_if.roi_y1);

  // Descending scan so the lowest matching index is the last to write class_s.
  always_comb begin
    class_s = 4'd0;
    for (int k = NUM_COLORS - 1; k >= 0; k--) begin
      class_s = thr_match(thr_q[k], pix_if.pixel_r, pix_if.pixel_g, pix_if.pixel_b) ?
                4'(k + 1) : class_s;
    end
  end

  // Snapshot entry currently visited by the arg-max scan.
  always_comb begin
    snap_sel_s = CNT_ZERO;
    for (int k = 0; k < NUM_COLORS; k++) begin
      snap_sel_s = (idx_q == 3'(k)) ? snap_q[k] : snap_sel_s;
    end
  end

  // Threshold table; out-of-range indices never match and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_COLORS; k++) thr_q[k] <= THR_CLEAR;
    end else begin
      for (int k = 0; k < NUM_COLORS; k++) begin
        if (pix_if.cfg_we && (pix_if.cfg_idx == 3'(k))) thr_q[k] <= pix_if.cfg_data;
      end
    end
  end

  // Stage 1 classification, frame-edge detect, histogram counters and snapshots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_q        <= 1'b0;
      fend_q      <= 1'b0;
      pix_class_q <= 4'd0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < NUM_COLORS; k++) begin
        count_q[k] <= CNT_ZERO;
        snap_q[k]  <= CNT_ZERO;
      end
    end else begin
      fs_q        <= pix_if.frame_start;
      fend_q      <= pix_if.frame_start & ~fs_q;
      pix_class_q <= (pix_if.pixel_valid && in_roi_s) ? class_s : 4'd0;
      overrun_q   <= fend_q && (state_q != ACCUM);
      for (int k = 0; k < NUM_COLORS; k++) begin
        if (fend_q) begin
          count_q[k] <= CNT_ZERO;
          // The pixel landing in stage 2 this cycle belongs to the closing frame.
          if (state_q == ACCUM) snap_q[k] <= sat_inc(count_q[k], pix_class_q == 4'(k + 1));
        end else begin
          count_q[k] <= sat_inc(count_q[k], pix_class_q == 4'(k + 1));
        end
      end
    end
  end

  // Arg-max scan, decision and debounce.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    best_d         = best_q;
    best_idx_d     = best_idx_q;
    win_s          = 4'd0;
    frame_color_d  = frame_color_q;
    frame_count_d  = frame_count_q;
    color_valid_d  = 1'b0;
    stable_color_d = stable_color_q;
    stable_valid_d = 1'b0;
    run_d          = run_q;
    case (state_q)
      ACCUM: begin
        if (fend_q) begin
          state_d    = SCAN;
          idx_d      = 3'd0;
          best_d     = CNT_ZERO;
          best_idx_d = 3'd0;
        end else begin
          state_d = ACCUM;
        end
      end
      SCAN: begin
        if (snap_sel_s > best_q) begin
          best_d     = snap_sel_s;
          best_idx_d = idx_q;
        end else begin
          best_d     = best_q;
          best_idx_d = best_idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DECIDE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DECIDE: begin
        win_s         = (best_q > MIN_CNT) ? ({1'b0, best_idx_q} + 4'd1) : 4'd0;
        frame_color_d = win_s;
        frame_count_d = (best_q > MIN_CNT) ? best_q : CNT_ZERO;
        color_valid_d = 1'b1;
        if (win_s == frame_color_q) begin
          run_d = (run_q < RUN_MAX) ? (run_q + RUN_ONE) : run_q;
        end else begin
          run_d = RUN_ONE;
        end
        if ((run_d == RUN_MAX) && (win_s != stable_color_q)) begin
          stable_color_d = win_s;
          stable_valid_d = 1'b1;
        end else begin
          stable_color_d = stable_color_q;
        end
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // FSM state and registered frame results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ACCUM;
      idx_q          <= 3'd0;
      best_q         <= CNT_ZERO;
      best_idx_q     <= 3'd0;
      frame_color_q  <= 4'd0;
      frame_count_q  <= CNT_ZERO;
      color_valid_q  <= 1'b0;
      stable_color_q <= 4'd0;
      stable_valid_q <= 1'b0;
      run_q          <= {RUN_W{1'b0}};
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      best_q         <= best_d;
      best_idx_q     <= best_idx_d;
      frame_color_q  <= frame_color_d;
      frame_count_q  <= frame_count_d;
      color_valid_q  <= color_valid_d;
      stable_color_q <= stable_color_d;
      stable_valid_q <= stable_valid_d;
      run_q          <= run_d;
      busy_q         <= (state_d != ACCUM);
    end
  end

`ifdef COLOR_HIST_READ_EN
  logic [COUNT_W-1:0] hist_sel_s, hist_q;

  // Debug read mux; unmapped indices read as zero.
  always_comb begin
    hist_sel_s = CNT_ZERO;
    for (int k = 0; k < NUM_COLORS; k++) begin
      hist_sel_s = (pix_if.hist_idx == 3'(k)) ? snap_q[k] : hist_sel_s;
    end
  end

  // Registered histogram read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= CNT_ZERO;
    else       hist_q <= hist_sel_s;
  end

  assign pix_if.hist_count = hist_q;
`endif

  assign pix_if.in_roi       = in_roi_s;
  assign pix_if.pix_class    = pix_class_q;
  assign pix_if.frame_color  = frame_color_q;
  assign pix_if.frame_count  = frame_count_q;
  assign pix_if.color_valid  = color_valid_q;
  assign pix_if.stable_color = stable_color_q;
  assign pix_if.stable_valid = stable_valid_q;
  assign pix_if.overrun      = overrun_q;
  assign pix_if.busy         = busy_q;

endmodule

// File: tb/tb_roi_color_classifier.sv
// Scoreboard bench for roi_color_classifier: each frame end pushes its hand-computed result,
// a negedge monitor pops and compares on every color_valid.
module tb_roi_color_classifier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  roi_color_classifier_if #(.COORD_W(10), .COUNT_W(16)) bus ();

  roi_color_classifier #(
    .NUM_COLORS(4), .COORD_W(10), .COUNT_W(16), .STABLE_FRAMES(3), .MIN_PIXELS(50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pix_if(bus)
  );

  typedef struct {
    logic [3:0]  fc;
    logic [15:0] cnt;
    logic        sv;
    logic [3:0]  sc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_fail    = 0;
  int   n_overrun = 0;
  int   n_cv      = 0;
  int   saved_cv;

  localparam logic [47:0] RED_T   = {8'd180, 8'd255, 8'd0, 8'd99,  8'd0,   8'd99};
  localparam logic [47:0] GREEN_T = {8'd0,   8'd99,  8'd180, 8'd255, 8'd0, 8'd99};
  localparam logic [47:0] TEAL_T  = {8'd0,   8'd120, 8'd150, 8'd255, 8'd0, 8'd120};
  localparam logic [47:0] BLUE_T  = {8'd0,   8'd99,  8'd0, 8'd99,  8'd180, 8'd255};
  localparam logic [47:0] ALL_T   = {8'd0,   8'd255, 8'd0, 8'd255, 8'd0,   8'd255};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Result monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.color_valid) begin
        n_cv++;
        if (sb.size() == 0) chk("cv_unexpected", {31'd0, bus.color_valid}, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("frame_color",  {28'd0, bus.frame_color},  {28'd0, mon_e.fc});
          chk("frame_count",  {16'd0, bus.frame_count},  {16'd0, mon_e.cnt});
          chk("stable_valid", {31'd0, bus.stable_valid}, {31'd0, mon_e.sv});
          chk("stable_color", {28'd0, bus.stable_color}, {28'd0, mon_e.sc});
          chk("cv_latency",   cyc,                        mon_e.cyc);
        end
      end else if (bus.stable_valid) begin
        chk("sv_without_cv", {31'd0, bus.stable_valid}, 32'd0);
      end
      if (bus.overrun) n_overrun++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pixel_valid = 1'b0;
    end
  endtask

  task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b, input logic v);
    bus.x_coord = x; bus.y_coord = y;
    bus.pixel_r = r; bus.pixel_g = g; bus.pixel_b = b;
    bus.pixel_valid = v;
  endtask

  task automatic send(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_px(10'd150, 10'd100, r, g, b, 1'b1);
    end
  endtask

  task automatic probe(input string nm, input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic v, input logic exp_roi, input logic [3:0] exp_cls);
    @(negedge clk);
    set_px(x, y, r, g, b, v);
    #1 chk({nm, "_in_roi"}, {31'd0, bus.in_roi}, {31'd0, exp_roi});
    @(negedge clk);
    chk({nm, "_pix_class"}, {28'd0, bus.pix_class}, {28'd0, exp_cls});
    bus.pixel_valid = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [47:0] data);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic frame_end(input logic [3:0] fc, input logic [15:0] cnt, input logic sv,
                           input logic [3:0] sc, input int hold);
    exp_t e;
    idle(3);
    @(negedge clk);
    e.fc = fc; e.cnt = cnt; e.sv = sv; e.sc = sc; e.cyc = cyc + 7;
    sb.push_back(e);
    bus.frame_start = 1'b1;
    repeat (hold) @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("result_pending", sb.size(), 32'd0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.frame_start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = 3'd0; bus.cfg_data = 48'd0;
    set_px(10'd0, 10'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    bus.roi_x0 = 10'd0; bus.roi_x1 = 10'd0; bus.roi_y0 = 10'd0; bus.roi_y1 = 10'd0;
`ifdef COLOR_HIST_READ_EN
    bus.hist_idx = 3'd0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_frame_color",  {28'd0, bus.frame_color}, 32'd0);
    chk("rst_frame_count",  {16'd0, bus.frame_count}, 32'd0);
    chk("rst_color_valid",  {31'd0, bus.color_valid}, 32'd0);
    chk("rst_stable_color", {28'd0, bus.stable_color}, 32'd0);
    chk("rst_busy",         {31'd0, bus.busy}, 32'd0);
    chk("rst_in_roi",       {31'd0, bus.in_roi}, 32'd0);

    bus.roi_x0 = 10'd100; bus.roi_x1 = 10'd220; bus.roi_y0 = 10'd60; bus.roi_y1 = 10'd180;
    probe("unprogrammed", 10'd150, 10'd100, 8'd250, 8'd20, 8'd20, 1'b1, 1'b1, 4'd0);
    cfg(3'd0, RED_T); cfg(3'd1, GREEN_T); cfg(3'd2, TEAL_T); cfg(3'd3, BLUE_T);
    cfg(3'd5, ALL_T);

    // Frame end with frame_start held for several cycles is a single event.
    send(200, 8'd250, 8'd20, 8'd20);  frame_end(4'd1, 16'd200, 1'b0, 4'd0, 4); wait_done();
    send(50,  8'd250, 8'd20, 8'd20);  frame_end(4'd0, 16'd0,   1'b0, 4'd0, 1); wait_done();
    send(51,  8'd250, 8'd20, 8'd20);  frame_end(4'd1, 16'd51,  1'b0, 4'd0, 1); wait_done();
    send(100, 8'd250, 8'd20, 8'd20);
    send(100, 8'd50,  8'd200, 8'd50); frame_end(4'd1, 16'd100, 1'b0, 4'd0, 1); wait_done();

    probe("prio_1_2",  10'd150, 10'd100, 8'd50,  8'd200, 8'd50,  1'b1, 1'b1, 4'd2);
    probe("teal_only", 10'd150, 10'd100, 8'd110, 8'd160, 8'd110, 1'b1, 1'b1, 4'd3);
    send(59, 8'd50, 8'd200, 8'd50);   frame_end(4'd2, 16'd60, 1'b0, 4'd0, 1); wait_done();
    send(60, 8'd50, 8'd200, 8'd50);   frame_end(4'd2, 16'd60, 1'b0, 4'd0, 1); wait_done();
    send(60, 8'd50, 8'd200, 8'd50);   frame_end(4'd2, 16'd60, 1'b1, 4'd2, 1); wait_done();
    send(60, 8'd250, 8'd20, 8'd20);   frame_end(4'd1, 16'd60, 1'b0, 4'd2, 1); wait_done();

    // Second edge while scanning: dropped result, counts (incl. this green pixel) cleared.
    send(60, 8'd20, 8'd20, 8'd250);   frame_end(4'd4, 16'd60, 1'b0, 4'd2, 1);
    set_px(10'd150, 10'd100, 8'd50, 8'd200, 8'd50, 1'b1);
    @(negedge clk);
    bus.pixel_valid = 1'b0; bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    wait_done();
    chk("overrun_pulses", n_overrun, 32'd1);
    send(55, 8'd50, 8'd200, 8'd50);   frame_end(4'd2, 16'd55, 1'b0, 4'd2, 1); wait_done();

    probe("x99",       10'd99,  10'd100, 8'd250, 8'd20, 8'd20, 1'b1, 1'b0, 4'd0);
    probe("x220",      10'd220, 10'd100, 8'd250, 8'd20, 8'd20, 1'b1, 1'b0, 4'd0);
    probe("y59",       10'd150, 10'd59,  8'd250, 8'd20, 8'd20, 1'b1, 1'b0, 4'd0);
    probe("y180",      10'd150, 10'd180, 8'd250, 8'd20, 8'd20, 1'b1, 1'b0, 4'd0);
    probe("lo_corner", 10'd100, 10'd60,  8'd250, 8'd20, 8'd20, 1'b1, 1'b1, 4'd1);
    probe("hi_corner", 10'd219, 10'd179, 8'd250, 8'd20, 8'd20, 1'b1, 1'b1, 4'd1);
    probe("not_valid", 10'd150, 10'd100, 8'd250, 8'd20, 8'd20, 1'b0, 1'b1, 4'd0);
    send(50, 8'd250, 8'd20, 8'd20);   frame_end(4'd1, 16'd52, 1'b0, 4'd2, 1); wait_done();

    // Reset while the arg-max is scanning: no result may appear.
    send(60, 8'd250, 8'd20, 8'd20);
    idle(3);
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_in_scan", {31'd0, bus.busy}, 32'd1);
    saved_cv = n_cv;
    reset = 1'b1;
    #1;
    chk("scanrst_frame_color",  {28'd0, bus.frame_color},  32'd0);
    chk("scanrst_frame_count",  {16'd0, bus.frame_count},  32'd0);
    chk("scanrst_stable_color", {28'd0, bus.stable_color}, 32'd0);
    chk("scanrst_busy",         {31'd0, bus.busy},         32'd0);
    chk("scanrst_color_valid",  {31'd0, bus.color_valid},  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(15);
    chk("no_cv_after_reset", n_cv, saved_cv);
    probe("thr_cleared", 10'd150, 10'd100, 8'd250, 8'd20, 8'd20, 1'b1, 1'b1, 4'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
